// File: rtl/wb_arbiter_pkg.sv
// rtl/wb_arbiter_pkg.sv - shared register-file constants for the write-back path
//
// Purpose: data width, register count, register-address width and the
// hard-wired zero register index, shared by the write-back arbiter and the
// register file so both agree on the write-port shape.
package wb_arbiter_pkg;

  localparam int unsigned XLEN_DEF    = 64;
  localparam int unsigned REG_NUM_DEF = 32;
  localparam int unsigned REG_AW      = 5;

  localparam logic [REG_AW-1:0] ZERO_REG = '0;

  // Channel index inside the two-bit request/grant vectors.
  typedef enum logic {
    CH_ALU = 1'b0,
    CH_LSU = 1'b1
  } wb_ch_e;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-requester round-robin grant
//
// Purpose: grants one of two requesters. A lone requester always wins. When
// both request, the one that lost the previous contest wins, and the pointer
// flips. Uncontested grants never move the pointer. After reset requester 0
// wins the first contest.
// Ports:
//   clk, rst   rising-edge clock, synchronous active-high reset
//   req[1:0]   requests (caller gates them low during reset)
//   gnt[1:0]   one-hot or zero grant, combinational from req and pointer
import wb_arbiter_pkg::*;

module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  // Set when requester 1 has priority in the next contest.
  logic pri1_q;
  logic pri1_d;

  always_comb begin
    gnt    = 2'b00;
    pri1_d = pri1_q;
    unique case (req)
      2'b01: gnt = 2'b01;
      2'b10: gnt = 2'b10;
      2'b11: begin
        // Every grant on a contest is a transfer, since the winner is valid
        // and its ready is the grant, so the pointer advances right here.
        gnt    = pri1_q ? 2'b10 : 2'b01;
        pri1_d = ~pri1_q;
      end
      default: gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pri1_q <= 1'b0;
    end else begin
      pri1_q <= pri1_d;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - ALU/LSU write-back arbiter with pending-write scoreboard
//
// Purpose: merges the ALU and load result channels onto a single registered
// register-file write port, and tracks which registers have a write in flight.
// Ports:
//   clk, rst                     rising-edge clock, synchronous active-high reset
//   alu_valid/ready/rd/data      ALU result channel (valid/ready handshake)
//   lsu_valid/ready/rd/data      load result channel (valid/ready handshake)
//   iss_en, iss_rd               issue marks iss_rd pending
//   wr_en, wr_addr, wr_data      registered register-file write port
//   busy[REG_NUM-1:0]            pending-write scoreboard, bit 0 always 0
import wb_arbiter_pkg::*;

module wb_arbiter #(
  parameter int unsigned XLEN    = XLEN_DEF,
  parameter int unsigned REG_NUM = REG_NUM_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               alu_valid,
  output logic               alu_ready,
  input  logic [REG_AW-1:0]  alu_rd,
  input  logic [XLEN-1:0]    alu_data,
  input  logic               lsu_valid,
  output logic               lsu_ready,
  input  logic [REG_AW-1:0]  lsu_rd,
  input  logic [XLEN-1:0]    lsu_data,
  input  logic               iss_en,
  input  logic [REG_AW-1:0]  iss_rd,
  output logic               wr_en,
  output logic [REG_AW-1:0]  wr_addr,
  output logic [XLEN-1:0]    wr_data,
  output logic [REG_NUM-1:0] busy
);

  logic [1:0]        req;
  logic [1:0]        gnt;
  logic              xfer;
  logic [REG_AW-1:0] sel_rd;
  logic [XLEN-1:0]   sel_data;

  logic               wr_en_q,   wr_en_d;
  logic [REG_AW-1:0]  wr_addr_q, wr_addr_d;
  logic [XLEN-1:0]    wr_data_q, wr_data_d;
  logic [REG_NUM-1:0] busy_q,    busy_d;

  // Masking requests during reset keeps both readies low and stops the
  // round-robin pointer from moving in a reset cycle.
  always_comb begin
    req         = 2'b00;
    req[CH_ALU] = alu_valid & ~rst;
    req[CH_LSU] = lsu_valid & ~rst;
  end

  rr_arb2 u_rr_arb2 (
    .clk (clk),
    .rst (rst),
    .req (req),
    .gnt (gnt)
  );

  assign alu_ready = gnt[CH_ALU];
  assign lsu_ready = gnt[CH_LSU];
  assign xfer      = |gnt;

  always_comb begin
    sel_rd   = alu_rd;
    sel_data = alu_data;
    if (gnt[CH_LSU]) begin
      sel_rd   = lsu_rd;
      sel_data = lsu_data;
    end
  end

  always_comb begin
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    busy_d    = busy_q;
    if (xfer) begin
      // A transfer to x0 is consumed but never becomes a write.
      wr_en_d         = (sel_rd != ZERO_REG);
      wr_addr_d       = sel_rd;
      wr_data_d       = sel_data;
      busy_d[sel_rd]  = 1'b0;
    end
    // Applied after the clear so a same-register issue keeps the bit set.
    if (iss_en && (iss_rd != ZERO_REG)) begin
      busy_d[iss_rd] = 1'b1;
    end
    busy_d[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= '0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - self-checking bench for wb_arbiter
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, lsu_valid, iss_en;
  logic        alu_ready, lsu_ready, wr_en;
  logic [4:0]  alu_rd, lsu_rd, iss_rd, wr_addr;
  logic [63:0] alu_data, lsu_data, wr_data;
  logic [31:0] busy;

  int checks = 0;
  int errors = 0;

  // Reference model state: who wins the next contest, the pending set,
  // and what the write port should show.
  bit          m_alu_turn;
  bit [31:0]   m_busy;
  bit          m_wr_en;
  bit [4:0]    m_wr_addr;
  bit [63:0]   m_wr_data;

  always #5 clk = ~clk;

  wb_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .lsu_valid (lsu_valid),
    .lsu_ready (lsu_ready),
    .lsu_rd    (lsu_rd),
    .lsu_data  (lsu_data),
    .iss_en    (iss_en),
    .iss_rd    (iss_rd),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus: drive at the falling edge, check readies, let the
  // rising edge happen, then check the registered outputs against the model.
  task automatic step(input bit r, input bit av, input bit [4:0] ard, input bit [63:0] adat,
                      input bit lv, input bit [4:0] lrd, input bit [63:0] ldat,
                      input bit ie, input bit [4:0] ird);
    bit g_alu, g_lsu;
    bit [4:0] trd;
    @(negedge clk);
    rst = r; alu_valid = av; alu_rd = ard; alu_data = adat;
    lsu_valid = lv; lsu_rd = lrd; lsu_data = ldat; iss_en = ie; iss_rd = ird;
    g_alu = 0; g_lsu = 0;
    if (!r) begin
      if (av && lv) begin
        g_alu = m_alu_turn;
        g_lsu = !m_alu_turn;
      end else begin
        g_alu = av;
        g_lsu = lv;
      end
    end
    #1;
    check("alu_ready", alu_ready, g_alu);
    check("lsu_ready", lsu_ready, g_lsu);
    if (r) begin
      m_alu_turn = 1; m_busy = 0; m_wr_en = 0; m_wr_addr = 0; m_wr_data = 0;
    end else begin
      if (av && lv) m_alu_turn = g_lsu;
      m_wr_en = 0;
      if (g_alu || g_lsu) begin
        trd       = g_alu ? ard : lrd;
        m_wr_en   = (trd != 0);
        m_wr_addr = trd;
        m_wr_data = g_alu ? adat : ldat;
        m_busy[trd] = 0;
      end
      if (ie && ird != 0) m_busy[ird] = 1;
    end
    @(posedge clk);
    #1;
    check("wr_en", wr_en, m_wr_en);
    check("wr_addr", wr_addr, m_wr_addr);
    check("wr_data", wr_data, m_wr_data);
    check("busy", busy, m_busy);
    check("busy0", busy[0], 1'b0);
  endtask

  task automatic idle(input bit r);
    step(r, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1; alu_valid = 0; lsu_valid = 0; iss_en = 0;
    alu_rd = 0; lsu_rd = 0; iss_rd = 0; alu_data = 0; lsu_data = 0;
    m_alu_turn = 1; m_busy = 0; m_wr_en = 0; m_wr_addr = 0; m_wr_data = 0;

    idle(1);
    idle(1);

    // Lone ALU request, rd=5, data=0xA5.
    step(0, 1, 5, 64'hA5, 0, 0, 0, 0, 0);
    check("lone_alu_addr", wr_addr, 5);
    check("lone_alu_data", wr_data, 64'hA5);
    idle(0);
    check("wr_en_idle", wr_en, 0);
    check("hold_addr", wr_addr, 5);

    // Contention for four cycles straight after reset: ALU, LSU, ALU, LSU.
    idle(1);
    step(0, 1, 1, 64'h11, 1, 2, 64'h22, 0, 0);
    check("contest1_addr", wr_addr, 1);
    step(0, 1, 3, 64'h33, 1, 4, 64'h44, 0, 0);
    check("contest2_addr", wr_addr, 4);
    step(0, 1, 5, 64'h55, 1, 6, 64'h66, 0, 0);
    check("contest3_addr", wr_addr, 5);
    step(0, 1, 7, 64'h77, 1, 8, 64'h88, 0, 0);
    check("contest4_addr", wr_addr, 8);

    // Uncontested grant leaves the pointer alone: next contest is ALU's.
    step(0, 0, 0, 0, 1, 9, 64'h99, 0, 0);
    step(0, 1, 10, 64'hAA, 1, 11, 64'hBB, 0, 0);
    check("after_lone_contest", wr_addr, 10);

    // Load to x0 is accepted but never written.
    step(0, 0, 0, 0, 1, 0, 64'hDEAD, 0, 0);
    check("x0_wr_en", wr_en, 0);

    // Scoreboard: issue 7, retire 7, then issue and retire 7 together.
    step(0, 0, 0, 0, 0, 0, 0, 1, 7);
    check("busy7_set", busy[7], 1);
    step(0, 1, 7, 64'h7, 0, 0, 0, 0, 0);
    check("busy7_clr", busy[7], 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 7);
    step(0, 1, 7, 64'h77, 0, 0, 0, 1, 7);
    check("busy7_setprio", busy[7], 1);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    check("busy0_issue", busy[0], 0);

    // Reset in the middle of contention with pending registers.
    step(0, 0, 0, 0, 0, 0, 0, 1, 12);
    step(0, 1, 13, 64'h1313, 1, 14, 64'h1414, 1, 15);
    step(1, 1, 16, 64'h1616, 1, 17, 64'h1717, 1, 18);
    check("rst_busy", busy, 0);
    check("rst_wr_en", wr_en, 0);
    step(0, 1, 19, 64'h1919, 1, 20, 64'h2020, 0, 0);
    check("post_rst_contest", wr_addr, 19);

    // Randomized traffic against the model, with occasional resets.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 39) == 0),
           $urandom_range(0, 1), 5'($urandom), {$urandom, $urandom},
           $urandom_range(0, 1), 5'($urandom), {$urandom, $urandom},
           $urandom_range(0, 1), 5'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
- REQ-001 SHALL have parameter XLEN, default 64: data width of the write port.
- REQ-002 SHALL have parameter REG_NUM, default 32: number of architectural registers; address width is 5.
- REQ-003 SHALL have one clock and a synchronous active-high reset: clk in 1, rising-edge clock; rst in 1, synchronous, active-high.
- REQ-004 SHALL have ports alu_valid in 1, alu_ready out 1, alu_rd in 5, alu_data in XLEN: ALU result channel.
- REQ-005 SHALL have ports lsu_valid in 1, lsu_ready out 1, lsu_rd in 5, lsu_data in XLEN: load-result channel.
- REQ-006 SHALL have ports iss_en in 1, iss_rd in 5: issue marks a destination register pending.
- REQ-007 SHALL have ports wr_en out 1, wr_addr out 5, wr_data out XLEN: registered drive of the register-file write port.
- REQ-008 SHALL have port busy out REG_NUM: pending-write scoreboard, bit i set means register i has an outstanding write.

Function
- REQ-009 SHALL transfer on a channel when valid and ready are both high at a rising clk edge.
- REQ-010 SHALL assert at most one of alu_ready / lsu_ready per cycle; ready is combinational from valid and arbiter state.
- REQ-011 SHALL grant the single requester when only one is valid; with none valid, both readies are low.
- REQ-012 SHALL arbitrate round-robin when both are valid: grant the channel not granted in the most recent two-way contest; after reset, ALU wins the first contest.
- REQ-013 SHALL update the round-robin pointer only on a contested transfer; uncontested grants leave it unchanged.
- REQ-014 SHALL register the granted rd/data into wr_addr/wr_data and assert wr_en in the cycle after transfer (latency 1).
- REQ-015 SHALL accept a transfer with rd = 0 without stalling, but keep wr_en low in the following cycle.
- REQ-016 SHALL deassert wr_en in every cycle not following a transfer; wr_addr/wr_data hold their last value.
- REQ-017 SHALL set busy[iss_rd] at the clock edge where iss_en is high and iss_rd != 0.
- REQ-018 SHALL clear busy[rd] at the edge where the transfer for rd is accepted (not when wr_en is driven).
- REQ-019 SHALL give set priority when an issue and a transfer name the same nonzero register in the same cycle: busy stays 1.
- REQ-020 SHALL hold busy[0] at 0 permanently.
- REQ-021 SHALL not require valid to be held; a withdrawn valid carries no obligation, and the arbiter ignores channel data while valid is low.

Reset
- REQ-022 SHALL, when rst is high at a clk edge, clear wr_en, wr_addr, wr_data, all busy bits, and set the round-robin pointer to favour ALU.
- REQ-023 SHALL drive alu_ready and lsu_ready low while rst is high; no transfer completes in a reset cycle.
- REQ-024 SHALL discard any write registered in the cycle before reset (wr_en low in the first cycle after reset).

Structure
- REQ-025 SHALL take XLEN, REG_NUM, the register-address width and a zero-register index constant from a shared package also used by the register file.
- REQ-026 SHALL factor the two-requester round-robin grant logic into sub-module rr_arb2 (req[1:0] in, gnt[1:0] out, internal last-winner flop, advance on contest).
- REQ-027 SHALL keep all state in the clk domain with no latches and no negedge logic.

Verification
- REQ-028 SHALL cover a lone ALU request: alu_valid=1, rd=5, data=0xA5 -> alu_ready=1 the same cycle; next cycle wr_en=1, wr_addr=5, wr_data=0xA5.
- REQ-029 SHALL cover contention: both valid for 4 cycles after reset -> grants ALU, LSU, ALU, LSU; wr_addr sequence matches.
- REQ-030 SHALL cover x0: lsu_valid=1, rd=0 -> lsu_ready=1; next cycle wr_en=0; busy[0]=0 throughout.
- REQ-031 SHALL cover the scoreboard: iss_en rd=7 -> busy[7]=1 next cycle; ALU transfer rd=7 -> busy[7]=0 next cycle; a simultaneous issue and transfer on rd=7 -> busy[7]=1.
- REQ-032 SHALL cover reset mid-traffic: rst during contention with busy bits set -> readies low; next cycle busy=0, wr_en=0; first contest after reset grants ALU.
